// File: rtl/alu_operand_fetch.sv
// Decode/operand-fetch stage feeding the 64-bit ALU: decodes RV64 ALU instructions to a
// 4-bit op and reads two operands from a 32x64 register file with write-back bypass.
// Latency: 1 cycle from accept to out_valid. Backpressure: single output register, no skid;
// in_ready = !out_valid | out_ready, so the packet is held bit-stable while stalled.
// Optional feature macro: ALU_IMM_OPS_EN (enables OP-IMM opcode 0010011 decode).
// Ports:
//   clk, rst                   clock, asynchronous active-high reset
//   in_valid/in_ready/in_instr instruction handshake and 32-bit instruction word
//   out_valid/out_ready        packet handshake toward the ALU
//   out_a/out_b/out_op/out_rd  registered packet: operands, 4-bit ALU op, destination index
//   wb_en/wb_rd/wb_data        ALU write-back port into the register file
//   illegal                    one-cycle pulse after accepting an undecodable instruction
module alu_operand_fetch #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_op,
  output logic [4:0]      out_rd,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  logic [XLEN-1:0] rf_q [NREGS];

  logic            valid_q, valid_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic [4:0]      rd_q, rd_d;
  logic            illegal_q, illegal_d;

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  logic [4:0]      rs1, rs2, rd;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            dec_legal;
  logic [3:0]      dec_op;
  logic [XLEN-1:0] dec_b;
  logic            accept;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  // Operand read with same-cycle write-back bypass; x0 is hardwired to zero.
  always_comb begin
    rs1_val = rf_q[rs1];
    rs2_val = rf_q[rs2];
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs1)) rs1_val = wb_data;
    if (wb_en && (wb_rd != 5'd0) && (wb_rd == rs2)) rs2_val = wb_data;
    if (rs1 == 5'd0) rs1_val = '0;
    if (rs2 == 5'd0) rs2_val = '0;
  end

  always_comb begin
    dec_legal = 1'b0;
    dec_op    = 4'd0;
    dec_b     = rs2_val;
    if (opcode == OPC_OP) begin
      dec_legal = 1'b1;
      case ({funct7, funct3})
        {7'h00, 3'b000}: dec_op = 4'd0;  // ADD
        {7'h20, 3'b000}: dec_op = 4'd1;  // SUB
        {7'h00, 3'b111}: dec_op = 4'd2;  // AND
        {7'h00, 3'b110}: dec_op = 4'd3;  // OR
        {7'h00, 3'b100}: dec_op = 4'd4;  // XOR
        {7'h00, 3'b101}: dec_op = 4'd5;  // SRL
        {7'h00, 3'b001}: dec_op = 4'd6;  // SLL
        {7'h20, 3'b101}: dec_op = 4'd7;  // SRA
        {7'h00, 3'b010}: dec_op = 4'd8;  // SLT
        {7'h00, 3'b011}: dec_op = 4'd9;  // SLTU
        default:         dec_legal = 1'b0;
      endcase
    end
`ifdef ALU_IMM_OPS_EN
    else if (opcode == OPC_OP_IMM) begin
      dec_legal = 1'b1;
      dec_b     = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
      case (funct3)
        3'b000: dec_op = 4'd0;  // ADDI
        3'b100: dec_op = 4'd4;  // XORI
        3'b110: dec_op = 4'd3;  // ORI
        3'b111: dec_op = 4'd2;  // ANDI
        3'b010: dec_op = 4'd8;  // SLTI
        3'b011: dec_op = 4'd9;  // SLTIU
        3'b001: begin           // SLLI: shamt is zero-extended, funct6 must be 0
          dec_op    = 4'd6;
          dec_b     = {{(XLEN-6){1'b0}}, in_instr[25:20]};
          dec_legal = (in_instr[31:26] == 6'b000000);
        end
        default: begin          // 3'b101: SRLI / SRAI distinguished by funct6
          dec_b = {{(XLEN-6){1'b0}}, in_instr[25:20]};
          if (in_instr[31:26] == 6'b000000)      dec_op = 4'd5;
          else if (in_instr[31:26] == 6'b010000) dec_op = 4'd7;
          else                                   dec_legal = 1'b0;
        end
      endcase
    end
`endif
  end

  // An illegal accept still consumes the output slot, so out_valid only survives
  // when the ALU is stalling, which cannot coincide with an accept anyway.
  always_comb begin
    valid_d   = valid_q && !out_ready;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rd_d      = rd_q;
    illegal_d = 1'b0;
    if (accept) begin
      if (dec_legal) begin
        valid_d = 1'b1;
        a_d     = rs1_val;
        b_d     = dec_b;
        op_d    = dec_op;
        rd_d    = rd;
      end else begin
        illegal_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= 4'd0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else begin
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rd_q      <= rd_d;
      illegal_q <= illegal_d;
      if (wb_en && (wb_rd != 5'd0)) rf_q[wb_rd] <= wb_data;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_op    = op_q;
  assign out_rd    = rd_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Directed bench for alu_operand_fetch: decode sweep, stall, bypass, illegal pulse,
// async reset and (when ALU_IMM_OPS_EN is defined) immediate decode.
module tb_alu_operand_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_a, out_b;
  logic [3:0]  out_op;
  logic [4:0]  out_rd;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  alu_operand_fetch dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_op(out_op), .out_rd(out_rd),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] r_instr(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction

  logic [6:0] sw_f7 [10] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h00, 7'h00};
  logic [2:0] sw_f3 [10] = '{3'b000, 3'b000, 3'b111, 3'b110, 3'b100, 3'b101, 3'b001, 3'b101, 3'b010, 3'b011};

  localparam logic [31:0] ADD_3_1_2 = 32'h002081B3;
  localparam logic [63:0] MAXPOS    = 64'h7FFF_FFFF_FFFF_FFFF;

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
    wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    #1;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_illegal", {63'd0, illegal}, 64'd0);
    check("rst_out_a", out_a, 64'd0);
    tick();
    rst = 1'b0;

    // Write x1=10, x2=20
    wb_en = 1'b1; wb_rd = 5'd1; wb_data = 64'd10;
    tick();
    wb_rd = 5'd2; wb_data = 64'd20;
    tick();
    wb_en = 1'b0;

    // ADD x3,x1,x2
    in_valid = 1'b1; in_instr = ADD_3_1_2;
    #1 check("add_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    in_valid = 1'b0;
    check("add_out_valid", {63'd0, out_valid}, 64'd1);
    check("add_out_a", out_a, 64'd10);
    check("add_out_b", out_b, 64'd20);
    check("add_out_op", {60'd0, out_op}, 64'd0);
    check("add_out_rd", {59'd0, out_rd}, 64'd3);
    tick();
    check("drain_valid", {63'd0, out_valid}, 64'd0);

    // Literal SUB and SRA encodings
    in_valid = 1'b1; in_instr = 32'h402081B3;
    tick();
    check("sub_op", {60'd0, out_op}, 64'd1);
    in_instr = 32'h4020D1B3;
    tick();
    check("sra_op", {60'd0, out_op}, 64'd7);

    // Sweep all R-type ops back to back; expected op index equals table index
    for (int i = 0; i < 10; i++) begin
      in_instr = r_instr(sw_f7[i], sw_f3[i], 5'd3, 5'd1, 5'd2);
      tick();
      check($sformatf("sweep_op_%0d", i), {60'd0, out_op}, 64'(i));
      check($sformatf("sweep_valid_%0d", i), {63'd0, out_valid}, 64'd1);
    end

    // Stall three cycles with a new instruction waiting; SLTU packet must hold
    out_ready = 1'b0; in_instr = ADD_3_1_2;
    for (int i = 0; i < 3; i++) begin
      #1 check("stall_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_op", {60'd0, out_op}, 64'd9);
      check("stall_a", out_a, 64'd10);
      check("stall_b", out_b, 64'd20);
    end
    out_ready = 1'b1;
    #1 check("release_in_ready", {63'd0, in_ready}, 64'd1);
    tick();
    check("release_op", {60'd0, out_op}, 64'd0);
    check("release_valid", {63'd0, out_valid}, 64'd1);

    // Bypass on rs1 in the accept cycle
    in_instr = ADD_3_1_2; wb_en = 1'b1; wb_rd = 5'd1; wb_data = MAXPOS;
    tick();
    check("byp_rs1_a", out_a, MAXPOS);
    check("byp_rs1_b", out_b, 64'd20);
    // rs1 == rs2 == x2, bypassed on both
    in_instr = 32'h002101B3; wb_rd = 5'd2; wb_data = 64'h55;
    tick();
    check("byp_both_a", out_a, 64'h55);
    check("byp_both_b", out_b, 64'h55);
    // Write to x0 in the same cycle as reading x0
    in_instr = 32'h002001B3; wb_rd = 5'd0; wb_data = 64'd5;
    tick();
    wb_en = 1'b0;
    check("x0_byp_a", out_a, 64'd0);
    check("x0_byp_b", out_b, 64'h55);
    // Registers now hold the bypassed values; x0 still zero
    in_instr = ADD_3_1_2;
    tick();
    check("rf_x1", out_a, MAXPOS);
    check("rf_x2", out_b, 64'h55);
    in_instr = 32'h002001B3;
    tick();
    check("rf_x0", out_a, 64'd0);

    // Illegal while a packet is being consumed: slot treated as consumed
    in_instr = 32'h00000000;
    tick();
    in_valid = 1'b0;
    check("ill_pulse", {63'd0, illegal}, 64'd1);
    check("ill_valid", {63'd0, out_valid}, 64'd0);
    tick();
    check("ill_pulse_end", {63'd0, illegal}, 64'd0);
    // Unknown funct7 (MUL) is illegal
    in_valid = 1'b1; in_instr = 32'h022081B3;
    tick();
    in_valid = 1'b0;
    check("mul_illegal", {63'd0, illegal}, 64'd1);
    check("mul_valid", {63'd0, out_valid}, 64'd0);
    tick();

    // ADDI x4,x1,-1
    in_valid = 1'b1; in_instr = 32'hFFF08213;
    tick();
    in_valid = 1'b0;
`ifdef ALU_IMM_OPS_EN
    check("addi_valid", {63'd0, out_valid}, 64'd1);
    check("addi_b", out_b, 64'hFFFF_FFFF_FFFF_FFFF);
    check("addi_op", {60'd0, out_op}, 64'd0);
    check("addi_rd", {59'd0, out_rd}, 64'd4);
    check("addi_a", out_a, MAXPOS);
    in_valid = 1'b1; in_instr = 32'h03F09213;  // SLLI x4,x1,63
    tick();
    check("slli_op", {60'd0, out_op}, 64'd6);
    check("slli_b", out_b, 64'd63);
    in_instr = 32'h43F0D213;                   // SRAI x4,x1,63
    tick();
    check("srai_op", {60'd0, out_op}, 64'd7);
    check("srai_b", out_b, 64'd63);
    in_instr = 32'h83F0D213;                   // bad funct6
    tick();
    in_valid = 1'b0;
    check("badf6_illegal", {63'd0, illegal}, 64'd1);
    check("badf6_valid", {63'd0, out_valid}, 64'd0);
`else
    check("addi_illegal", {63'd0, illegal}, 64'd1);
    check("addi_valid", {63'd0, out_valid}, 64'd0);
`endif
    tick();

    // Async reset with a packet pending
    in_valid = 1'b1; in_instr = ADD_3_1_2;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", {63'd0, out_valid}, 64'd0);
    check("async_rst_a", out_a, 64'd0);
    check("async_rst_op", {60'd0, out_op}, 64'd0);
    tick();
    rst = 1'b0; out_ready = 1'b1;
    // Register file cleared by reset
    in_valid = 1'b1; in_instr = ADD_3_1_2;
    tick();
    in_valid = 1'b0;
    check("post_rst_a", out_a, 64'd0);
    check("post_rst_b", out_b, 64'd0);
    check("post_rst_valid", {63'd0, out_valid}, 64'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
